alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit Operation code from the ALU controller, together with two operands, over a valid/ready handshake.
- Returns a registered result and a branch-taken flag.
- Single-cycle ops complete on the accept edge. Shifts, and optionally MUL, run iteratively in a small FSM, stalling the input handshake while busy.
- Sits between ID/EX operand latch and EX/MEM register.

---
 rtl/alu_exec_pkg.sv | 36 +++
 rtl/alu_exec_unit_iter.sv | 82 ++++++++
 rtl/alu_exec_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, iterative
// step kinds, FSM states and the iteration counter width helper.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_BNE = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_BGE = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  // Per-edge step performed by the iterative unit
  localparam logic [1:0] IT_SLL = 2'd0;
  localparam logic [1:0] IT_SRL = 2'd1;
  localparam logic [1:0] IT_SRA = 2'd2;
  localparam logic [1:0] IT_MUL = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_t;

  // Counter must hold values 0..w inclusive (w = full multiply length)
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_exec_unit_iter.sv
// Iterative datapath for multi-cycle ALU ops: one-bit shifts and, when
// ALU_MUL_EN is defined, shift-add multiplication. Loaded by start, counts
// down one step per edge; done flags the edge producing the final value.
module alu_iter_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        kind,
  input  logic [DATA_W-1:0] a,
`ifdef ALU_MUL_EN
  input  logic [DATA_W-1:0] b,
`endif
  input  logic [CNT_W-1:0]  cnt_init,
  output logic [DATA_W-1:0] step_val,
  output logic              done
);

  logic [DATA_W-1:0]        acc_p0;
  logic signed [DATA_W-1:0] acc_s_p0;
  logic [CNT_W-1:0]         cnt_p0;
  logic [1:0]               kind_p0;
`ifdef ALU_MUL_EN
  logic [DATA_W-1:0]        mcand_p0;
  logic [DATA_W-1:0]        mplier_p0;
`endif

  assign acc_s_p0 = acc_p0;
  assign done     = (cnt_p0 == CNT_W'(1));

  // p0 -> p0: value the accumulator takes on the next step
  always_comb begin
    step_val = acc_p0;
    case (kind_p0)
      IT_SLL:  step_val = acc_p0 << 1;
      IT_SRL:  step_val = acc_p0 >> 1;
      IT_SRA:  step_val = acc_s_p0 >>> 1;
`ifdef ALU_MUL_EN
      IT_MUL:  step_val = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
`endif
      default: step_val = acc_p0;
    endcase
  end

  // p0: accumulator and step counter
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0  <= '0;
      cnt_p0  <= '0;
      kind_p0 <= IT_SLL;
    end else if (start) begin
`ifdef ALU_MUL_EN
      acc_p0  <= (kind == IT_MUL) ? '0 : a;
`else
      acc_p0  <= a;
`endif
      cnt_p0  <= cnt_init;
      kind_p0 <= kind;
    end else if (cnt_p0 != '0) begin
      acc_p0  <= step_val;
      cnt_p0  <= cnt_p0 - CNT_W'(1);
    end
  end

`ifdef ALU_MUL_EN
  // p0: multiplicand walks left, multiplier walks right, one bit per step
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p0  <= a;
      mplier_p0 <= b;
    end else if (cnt_p0 != '0) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake on both sides. Single-cycle
// ops register on the accept edge; shifts (and MUL when ALU_MUL_EN is
// defined) run in alu_iter_unit while the input handshake is stalled.
// Without ALU_MUL_EN, code 1100 is reported as illegal.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              BranchTaken,
  output logic              Illegal
);

  localparam int CNT_W = cnt_width(DATA_W);

  state_t                   state_p0, state_nx;
  logic                     vld_p1;
  logic [DATA_W-1:0]        res_p1;
  logic                     br_p1;
  logic                     ill_p1;

  logic signed [DATA_W-1:0] sa, sb;
  logic [DATA_W-1:0]        diff;
  logic [SHAMT_W-1:0]       shamt;
  logic [DATA_W-1:0]        res_c;
  logic                     br_c;
  logic                     ill_c;
  logic                     iter_go;
  logic [1:0]               iter_kind;
  logic [CNT_W-1:0]         iter_cnt;
  logic                     accept;
  logic                     start;
  logic                     iter_fin;
  logic [DATA_W-1:0]        step_val;
  logic                     done;

  assign sa     = SrcA;
  assign sb     = SrcB;
  assign diff   = SrcA - SrcB;
  assign shamt  = SrcB[SHAMT_W-1:0];

  // The unit only accepts when idle and the output register is (being) drained
  assign in_ready = (state_p0 == IDLE) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  assign start    = accept && iter_go;
  assign iter_fin = (state_p0 != IDLE) && done;

  assign out_valid   = vld_p1;
  assign ALUResult   = res_p1;
  assign BranchTaken = br_p1;
  assign Illegal     = ill_p1;

  // p0: decode, single-cycle results and iterative launch parameters
  always_comb begin
    res_c     = '0;
    br_c      = 1'b0;
    ill_c     = 1'b0;
    iter_go   = 1'b0;
    iter_kind = IT_SLL;
    iter_cnt  = '0;
    case (Operation)
      OP_AND: res_c = SrcA & SrcB;
      OP_OR:  res_c = SrcA | SrcB;
      OP_XOR: res_c = SrcA ^ SrcB;
      OP_ADD: res_c = SrcA + SrcB;
      OP_SUB: res_c = diff;
      OP_BNE: begin res_c = diff; br_c = (SrcA != SrcB); end
      OP_BEQ: begin res_c = diff; br_c = (SrcA == SrcB); end
      OP_BLT: begin res_c = diff; br_c = (sa < sb);      end
      OP_BGE: begin res_c = diff; br_c = (sa >= sb);     end
      OP_SLL, OP_SRL, OP_SRA: begin
        // Zero shift amount finishes immediately with SrcA unchanged
        res_c     = SrcA;
        iter_go   = (shamt != '0);
        iter_cnt  = CNT_W'(shamt);
        iter_kind = (Operation == OP_SLL) ? IT_SLL :
                    (Operation == OP_SRL) ? IT_SRL : IT_SRA;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        iter_go   = 1'b1;
        iter_kind = IT_MUL;
        iter_cnt  = CNT_W'(DATA_W);
      end
`endif
      default: ill_c = 1'b1;
    endcase
  end

  // p0: FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_p0 <= IDLE;
    else       state_p0 <= state_nx;
  end

  // p0: FSM next state
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_nx = (iter_kind == IT_MUL) ? MUL : SHIFT;
`else
          state_nx = SHIFT;
`endif
        end
      end
      SHIFT:   if (done) state_nx = IDLE;
`ifdef ALU_MUL_EN
      MUL:     if (done) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // p0 -> p1: output register, loaded by single-cycle accept or iteration end
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      br_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (accept && !iter_go) begin
      vld_p1 <= 1'b1;
      res_p1 <= res_c;
      br_p1  <= br_c;
      ill_p1 <= ill_c;
    end else if (iter_fin) begin
      vld_p1 <= 1'b1;
      res_p1 <= step_val;
      br_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  alu_iter_unit #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .kind     (iter_kind),
    .a        (SrcA),
`ifdef ALU_MUL_EN
    .b        (SrcB),
`endif
    .cnt_init (iter_cnt),
    .step_val (step_val),
    .done     (done)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors push expected results,
// a monitor pops and compares each output transfer.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        BranchTaken;
  logic        Illegal;

  typedef struct packed {
    logic [31:0] res;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Operation   (Operation),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUResult   (ALUResult),
    .BranchTaken (BranchTaken),
    .Illegal     (Illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h expected none", ALUResult);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", ALUResult, e.res);
        chk("branch", {31'd0, BranchTaken}, {31'd0, e.br});
        chk("illegal", {31'd0, Illegal}, {31'd0, e.ill});
      end
    end
  end

  // Present an op and hold it until accepted; called at posedge+1, returns at posedge+1
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eb, input logic ei, input bit push);
    bit got;
    got = 1'b0;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    for (int w = 0; w < 100 && !got; w++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (push) q.push_back('{er, eb, ei});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  // Count cycles from accept until out_valid, checking the input side stays stalled
  task automatic wait_out(input string nm, input int exp_lat);
    int  n;
    int  leak;
    bit  seen;
    n = 0; leak = 0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        n++;
        if (in_ready) leak++;
      end
    end
    chk({nm, "_latency"}, n, exp_lat);
    if (exp_lat > 0) chk({nm, "_busy_in_ready"}, leak, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic eb,
                     input logic ei, input int lat);
    issue(op, a, b, er, eb, ei, 1'b1);
    wait_out(nm, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stale;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = 4'd0; SrcA = '0; SrcB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_branch", {31'd0, BranchTaken}, 32'd0);
    chk("rst_illegal", {31'd0, Illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    run("add",      OP_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 0);
    run("sub",      OP_SUB, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0, 0);
    run("add_wrap", OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 0);
    run("and",      OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 0);
    run("or",       OP_OR,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0, 1'b0, 0);
    run("xor",      OP_XOR, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0, 1'b0, 0);
    run("blt",      OP_BLT, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b1, 1'b0, 0);
    run("bge",      OP_BGE, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFE,  1'b0, 1'b0, 0);
    run("beq",      OP_BEQ, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 0);
    run("bne",      OP_BNE, 32'd9,          32'd9,          32'd0,          1'b0, 1'b0, 0);
    run("bne_diff", OP_BNE, 32'd9,          32'd4,          32'd5,          1'b1, 1'b0, 0);
    run("sll4",     OP_SLL, 32'd1,          32'd4,          32'd16,         1'b0, 1'b0, 4);
    run("srl4",     OP_SRL, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0, 4);
    run("sra31",    OP_SRA, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF,  1'b0, 1'b0, 31);
    run("sll0",     OP_SLL, 32'h0000_1234,  32'd32,         32'h0000_1234,  1'b0, 1'b0, 0);
    run("illegal",  4'b1111, 32'd3,         32'd4,          32'd0,          1'b0, 1'b1, 0);
`ifdef ALU_MUL_EN
    run("mul",      OP_MUL, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0, 32);
`else
    run("mul_off",  OP_MUL, 32'd6,          32'd7,          32'd0,          1'b0, 1'b1, 0);
`endif

    // Backpressure: result must hold while the consumer stalls
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", ALUResult, 32'd7);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result", ALUResult, 32'd30);
    @(posedge clk); #1;

    // Reset in the middle of a long shift discards it
    issue(OP_SLL, 32'd1, 32'd10, 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("midrst_stale", stale, 0);
    @(posedge clk); #1;

    run("post_rst_add", OP_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
